// File: rtl/mp3_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : mp3_vga_timing
// Purpose  : VGA raster timing generator feeding mp3_display. A clock-enable
//            divider derives the pixel rate from the system clock. Registered
//            x/y counters produce the pixel coordinates. Sync and data-enable
//            are decoded from those counters, then delayed by PIPE_DLY pixel
//            ticks so they line up with the display's ROM-read latency.
// Ports    : clk           - system clock
//            rst           - asynchronous reset, active-high
//            i_en          - timing run enable
//            o_pix_ce      - one-clk pixel tick
//            o_x, o_y      - raster coordinates (16 bit)
//            o_vs          - undelayed vsync, active-high
//            o_de          - undelayed active-video flag
//            o_frame_start - one-clk pulse at the frame wrap
//            o_hsync       - delayed hsync, active level HS_POL
//            o_vsync       - delayed vsync, active level VS_POL
//            o_de_d        - delayed active-video flag
// Revision : 1.0 - initial release
// ============================================================================
module mp3_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic        o_pix_ce,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_vs,
    output logic        o_de,
    output logic        o_frame_start,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de_d
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] c_H_LAST     = 16'(c_H_TOTAL - 1);
    localparam logic [15:0] c_V_LAST     = 16'(c_V_TOTAL - 1);
    localparam logic [15:0] c_H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0] c_V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0] c_HS_FIRST   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_HS_LAST    = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] c_VS_FIRST   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_VS_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A width of at least one bit keeps CLK_DIV=1 legal; the counter then
    // simply stays at zero and the tick is asserted every clock.
    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_pix_ce;
    logic               r_run;
    logic               r_frame_start;
    logic [15:0]        r_x;
    logic [15:0]        r_y;

    logic w_x_wrap;
    logic w_y_wrap;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_de;
    logic w_hs_dly;
    logic w_vs_dly;
    logic w_de_dly;

    // ------------------------------------------------------------------
    // Pixel clock-enable divider. r_run marks that the raster is live; it
    // masks the data-enable decode, which would otherwise read as active
    // at the parked (0,0) position while held in reset or disabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_pix_ce  <= 1'b0;
            r_run     <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_pix_ce  <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_pix_ce  <= (r_div_cnt == c_DIV_LAST);
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign w_x_wrap = (r_x == c_H_LAST);
    assign w_y_wrap = (r_y == c_V_LAST);

    // ------------------------------------------------------------------
    // Raster counters, advanced by the registered pixel tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else if (!i_en) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= r_pix_ce && w_x_wrap && w_y_wrap;
            if (r_pix_ce) begin
                if (w_x_wrap) begin
                    r_x <= '0;
                    r_y <= w_y_wrap ? '0 : r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
        end
    end

    // Decodes straight from the counter registers: zero skew to o_x/o_y.
    assign w_de     = r_run && (r_x < c_H_ACT) && (r_y < c_V_ACT);
    assign w_hs_raw = (r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST);
    assign w_vs_raw = (r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST);

    // ------------------------------------------------------------------
    // Delay line holding {hs, vs, de} as active-high flags; polarity is
    // applied only at the output so "inactive" is always all-zeros.
    // ------------------------------------------------------------------
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign w_hs_dly = w_hs_raw;
            assign w_vs_dly = w_vs_raw;
            assign w_de_dly = w_de;
        end else begin : g_dly
            logic [2:0] r_dly [PIPE_DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_dly[i] <= 3'b000;
                end else if (!i_en) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_dly[i] <= 3'b000;
                end else if (r_pix_ce) begin
                    r_dly[0] <= {w_hs_raw, w_vs_raw, w_de};
                    for (int i = 1; i < PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign {w_hs_dly, w_vs_dly, w_de_dly} = r_dly[PIPE_DLY-1];
        end
    endgenerate

    assign o_pix_ce      = r_pix_ce;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_vs          = w_vs_raw;
    assign o_de          = w_de;
    assign o_frame_start = r_frame_start;
    assign o_hsync       = w_hs_dly ? HS_POL : ~HS_POL;
    assign o_vsync       = w_vs_dly ? VS_POL : ~VS_POL;
    assign o_de_d        = w_de_dly;

endmodule
`default_nettype wire

// File: tb/tb_mp3_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp3_vga_timing
// Purpose  : Self-checking bench for mp3_vga_timing. Three instances share
//            clk/rst/i_en: A (small raster, divide-by-4, 2-tick delay),
//            B (small raster, divide-by-1, no delay, inverted polarities)
//            and C (default 640x480 timing). Every falling edge all three are
//            compared with a model that maps "clocks since the raster started"
//            straight to coordinates; hand-derived vectors and sequences
//            cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp3_vga_timing;

    typedef struct packed {
        logic        pix_ce;
        logic [15:0] x;
        logic [15:0] y;
        logic        vs;
        logic        de;
        logic        fs;
        logic        hsync;
        logic        vsync;
        logic        de_d;
    } out_t;

    typedef struct {
        int   inst;
        int   k;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst;
    logic i_en;
    int   run_k;      // active clock edges since the raster (re)started
    int   n_cmp;
    int   n_fail;

    logic        a_pc, a_vs, a_de, a_fs, a_hs, a_vsn, a_ded;
    logic [15:0] a_x, a_y;
    logic        b_pc, b_vs, b_de, b_fs, b_hs, b_vsn, b_ded;
    logic [15:0] b_x, b_y;
    logic        c_pc, c_vs, c_de, c_fs, c_hs, c_vsn, c_ded;
    logic [15:0] c_x, c_y;
    out_t        a_out, b_out, c_out;

    assign a_out = {a_pc, a_x, a_y, a_vs, a_de, a_fs, a_hs, a_vsn, a_ded};
    assign b_out = {b_pc, b_x, b_y, b_vs, b_de, b_fs, b_hs, b_vsn, b_ded};
    assign c_out = {c_pc, c_x, c_y, c_vs, c_de, c_fs, c_hs, c_vsn, c_ded};

    mp3_vga_timing #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_en(i_en), .o_pix_ce(a_pc), .o_x(a_x), .o_y(a_y),
        .o_vs(a_vs), .o_de(a_de), .o_frame_start(a_fs), .o_hsync(a_hs),
        .o_vsync(a_vsn), .o_de_d(a_ded)
    );

    mp3_vga_timing #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_en(i_en), .o_pix_ce(b_pc), .o_x(b_x), .o_y(b_y),
        .o_vs(b_vs), .o_de(b_de), .o_frame_start(b_fs), .o_hsync(b_hs),
        .o_vsync(b_vsn), .o_de_d(b_ded)
    );

    mp3_vga_timing u_dut_c (
        .clk(clk), .rst(rst), .i_en(i_en), .o_pix_ce(c_pc), .o_x(c_x), .o_y(c_y),
        .o_vs(c_vs), .o_de(c_de), .o_frame_start(c_fs), .o_hsync(c_hs),
        .o_vsync(c_vsn), .o_de_d(c_ded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)        run_k <= 0;
        else if (!i_en) run_k <= 0;
        else            run_k <= run_k + 1;
    end

    // ------------------------------------------------------------------
    // Reference model: after k active edges the raster has completed
    // (k-1)/D pixels; coordinates follow by division, the delayed signals
    // are the decode of the pixel PD positions earlier.
    // ------------------------------------------------------------------
    function automatic out_t model(input int k, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int va, input int vfp, input int vsw,
                                   input int vbp, input int d, input int pd,
                                   input bit hp, input bit vp);
        out_t o;
        int ht, vt, p, q, px, py, qx, qy;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        o = '0;
        o.hsync = ~hp;
        o.vsync = ~vp;
        if (k == 0) return o;
        p  = (k - 1) / d;
        px = p % ht;
        py = (p / ht) % vt;
        o.pix_ce = (k >= d) && (k % d == 0);
        o.x  = 16'(px);
        o.y  = 16'(py);
        o.de = (px < ha) && (py < va);
        o.vs = (py >= va + vfp) && (py < va + vfp + vsw);
        o.fs = (k > 1) && ((k - 1) % d == 0) && (p % (ht * vt) == 0);
        q = p - pd;
        if (q >= 0) begin
            qx = q % ht;
            qy = (q / ht) % vt;
            o.hsync = ((qx >= ha + hfp) && (qx < ha + hfp + hsw)) ? hp : ~hp;
            o.vsync = ((qy >= va + vfp) && (qy < va + vfp + vsw)) ? vp : ~vp;
            o.de_d  = (qx < ha) && (qy < va);
        end
        return o;
    endfunction

    function automatic out_t mk(input bit pc, input int x, input int y, input bit vs,
                                input bit de, input bit fs, input bit hs, input bit vsn,
                                input bit ded);
        out_t o;
        o.pix_ce = pc; o.x = 16'(x); o.y = 16'(y); o.vs = vs; o.de = de;
        o.fs = fs; o.hsync = hs; o.vsync = vsn; o.de_d = ded;
        return o;
    endfunction

    function automatic out_t pick(input int inst);
        case (inst)
            0:       return a_out;
            1:       return b_out;
            default: return c_out;
        endcase
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s k=%0d actual=%h required=%h", name, run_k, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: step to the falling edge and compare all instances.
    task automatic tick();
        @(negedge clk);
        check_out("model_a", a_out, model(run_k, 16, 4, 6, 4, 8, 2, 2, 3, 4, 2, 1'b0, 1'b0));
        check_out("model_b", b_out, model(run_k, 16, 4, 6, 4, 8, 2, 2, 3, 1, 0, 1'b1, 1'b1));
        check_out("model_c", c_out,
                  model(run_k, 640, 16, 96, 48, 480, 10, 2, 33, 4, 2, 1'b0, 1'b0));
    endtask

    task automatic run_to(input int tgt);
        int guard;
        guard = 0;
        while (run_k < tgt && guard < 20000) begin
            tick();
            guard++;
        end
        check_val("reach_k", run_k, tgt);
    endtask

    vec_t tbl[$];

    initial begin
        int cnt;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        i_en   = 1'b1;

        //            inst k     pc x    y   vs de fs hs vsn ded
        tbl.push_back('{0, 1,    mk(0, 0,   0,  0, 1, 0, 1, 1, 0)});
        tbl.push_back('{1, 2,    mk(1, 1,   0,  0, 1, 0, 0, 0, 1)});
        tbl.push_back('{0, 4,    mk(1, 0,   0,  0, 1, 0, 1, 1, 0)});
        tbl.push_back('{0, 5,    mk(0, 1,   0,  0, 1, 0, 1, 1, 0)});
        tbl.push_back('{0, 9,    mk(0, 2,   0,  0, 1, 0, 1, 1, 1)});
        tbl.push_back('{1, 20,   mk(1, 19,  0,  0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 22,   mk(1, 21,  0,  0, 0, 0, 1, 0, 0)});
        tbl.push_back('{0, 81,   mk(0, 20,  0,  0, 0, 0, 1, 1, 0)});
        tbl.push_back('{0, 89,   mk(0, 22,  0,  0, 0, 0, 0, 1, 0)});
        tbl.push_back('{0, 113,  mk(0, 28,  0,  0, 0, 0, 1, 1, 0)});
        tbl.push_back('{0, 121,  mk(0, 0,   1,  0, 1, 0, 1, 1, 0)});
        tbl.push_back('{1, 451,  mk(1, 0,   0,  0, 1, 1, 0, 0, 1)});
        tbl.push_back('{0, 1201, mk(0, 0,   10, 1, 0, 0, 1, 1, 0)});
        tbl.push_back('{0, 1209, mk(0, 2,   10, 1, 0, 0, 1, 0, 0)});
        tbl.push_back('{0, 1801, mk(0, 0,   0,  0, 1, 1, 1, 1, 0)});
        tbl.push_back('{0, 1805, mk(0, 1,   0,  0, 1, 0, 1, 1, 0)});
        tbl.push_back('{2, 2625, mk(0, 656, 0,  0, 0, 0, 1, 1, 0)});
        tbl.push_back('{2, 2633, mk(0, 658, 0,  0, 0, 0, 0, 1, 0)});
        tbl.push_back('{2, 3013, mk(0, 753, 0,  0, 0, 0, 0, 1, 0)});
        tbl.push_back('{2, 3017, mk(0, 754, 0,  0, 0, 0, 1, 1, 0)});
        tbl.push_back('{2, 3197, mk(0, 799, 0,  0, 0, 0, 1, 1, 0)});
        tbl.push_back('{2, 3201, mk(0, 0,   1,  0, 1, 0, 1, 1, 0)});

        // Reset held for three clocks: model at k=0 is the reset state.
        repeat (3) tick();
        check_out("reset_a", a_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        check_out("reset_b", b_out, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_to(tbl[i].k);
            check_out($sformatf("vec%0d", i), pick(tbl[i].inst), tbl[i].exp);
        end

        // Mid-frame reset on A at (22,10) with both delayed syncs active.
        run_to(4889);
        check_out("pre_rst_a", a_out, mk(0, 22, 10, 1, 0, 0, 0, 0, 0));
        #2 rst = 1'b1;
        #1;
        check_out("async_rst_a", a_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        check_out("async_rst_c", c_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        tick();
        rst = 1'b0;

        // Enable drop on C at x=700, inside the delayed hsync pulse.
        run_to(2801);
        check_out("pre_en_c", c_out, mk(0, 700, 0, 0, 0, 0, 0, 1, 0));
        i_en = 1'b0;
        tick();
        check_out("en_drop_c", c_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        repeat (3) tick();
        check_out("en_idle_a", a_out, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));

        i_en = 1'b1;
        cnt  = 0;
        while (a_pc !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check_val("first_pix_ce_clk", cnt, 4);
        check_val("x_before_tick", a_x, 0);
        tick();
        check_val("x_after_tick", a_x, 1);
        check_val("pix_ce_one_clk", a_pc, 0);

        // A few random idle/run bursts, all covered by the per-clock model.
        for (int r = 0; r < 6; r++) begin
            i_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 60)) tick();
        end
        i_en = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
